// File: rtl/sdr_mon_pkg.sv
// Shared types for the SDRAM bank protocol monitor: command decode, bank states and
// violation codes.
package sdr_mon_pkg;

    typedef enum logic [3:0] {
        CmdLmr = 4'b0000,
        CmdRef = 4'b0001,
        CmdPre = 4'b0010,
        CmdAct = 4'b0011,
        CmdWr  = 4'b0100,
        CmdRd  = 4'b0101,
        CmdBst = 4'b0110,
        CmdNop = 4'b0111
    } cmd_t;

    typedef enum logic [2:0] {
        BkIdle,
        BkActivating,
        BkActive,
        BkPrecharging,
        BkRefreshing
    } bank_state_t;

    typedef enum logic [2:0] {
        VNone        = 3'd0,
        VActNotIdle  = 3'd1,
        VRwNotActive = 3'd2,
        VTiming      = 3'd4,
        VNotAllIdle  = 3'd5,
        VBadBank     = 3'd6
    } viol_code_t;

    function automatic cmd_t decode_cmd(input logic cs_n, input logic ras_n,
                                        input logic cas_n, input logic we_n);
        if (cs_n) begin
            return CmdNop;
        end
        return cmd_t'({1'b0, ras_n, cas_n, we_n});
    endfunction

endpackage

// File: rtl/sdr_bank_fsm.sv
// State and timing countdown for one SDRAM bank; advances only on commands the
// top level has already judged legal.
module sdr_bank_fsm
    import sdr_mon_pkg::*;
#(
    parameter int unsigned TmrW = 4,
    parameter int unsigned TRcd = 2,
    parameter int unsigned TRp  = 2,
    parameter int unsigned TRfc = 7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [3:0] cmd_i,
    input  logic       hit_i,
    input  logic       a10_i,
    input  logic       allow_i,
    output logic [2:0] state_o,
    output logic       busy_o
);

    localparam logic [TmrW-1:0] LdRcd = TmrW'(TRcd - 1);
    localparam logic [TmrW-1:0] LdRp  = TmrW'(TRp - 1);
    localparam logic [TmrW-1:0] LdRfc = TmrW'(TRfc - 1);

    bank_state_t     state_q, state_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    cmd_t            cmd;

    assign cmd = cmd_t'(cmd_i);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        if (tmr_q != '0) begin
            tmr_d = tmr_q - 1'b1;
        end
        if (allow_i) begin
            case (cmd)
                CmdAct: begin
                    if (hit_i) begin
                        state_d = BkActivating;
                        tmr_d   = LdRcd;
                    end
                end
                CmdRd, CmdWr: begin
                    if (hit_i && a10_i) begin
                        state_d = BkPrecharging;
                        tmr_d   = LdRp;
                    end
                end
                CmdPre: begin
                    if ((hit_i || a10_i) && state_q == BkActive) begin
                        state_d = BkPrecharging;
                        tmr_d   = LdRp;
                    end
                end
                CmdRef: begin
                    state_d = BkRefreshing;
                    tmr_d   = LdRfc;
                end
                default: ;
            endcase
        end
        // Transitional states settle the cycle the timer is zero, including 1-cycle loads.
        if (tmr_d == '0) begin
            case (state_d)
                BkActivating:                state_d = BkActive;
                BkPrecharging, BkRefreshing: state_d = BkIdle;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            state_q <= BkIdle;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    assign state_o = state_q;
    assign busy_o  = (tmr_q != '0);

endmodule

// File: rtl/sdr_bank_monitor.sv
// Passive multi-bank SDRAM command checker: per-bank FSMs plus legality decode,
// registered violation report and saturating violation counter.
module sdr_bank_monitor
    import sdr_mon_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned BA_W      = 2,
    parameter int unsigned T_RCD     = 2,
    parameter int unsigned T_RP      = 2,
    parameter int unsigned T_RFC     = 7,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 sdram_clk,
    input  logic                 sdram_reset,
    input  logic                 sdr_init_done,
    input  logic                 sdr_cs_n,
    input  logic                 sdr_ras_n,
    input  logic                 sdr_cas_n,
    input  logic                 sdr_we_n,
    input  logic [BA_W-1:0]      sdr_ba,
    input  logic                 sdr_a10,
    output logic                 viol,
    output logic [2:0]           viol_code,
    output logic [BA_W-1:0]      viol_bank,
    output logic [CNT_W-1:0]     viol_cnt,
    output logic [NUM_BANKS-1:0] bank_open
);

    localparam int unsigned TMax1    = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int unsigned TMax     = (TMax1 > T_RFC) ? TMax1 : T_RFC;
    localparam int unsigned TmrW     = $clog2(TMax) + 1;
    localparam logic [BA_W:0] NumBnk = (BA_W + 1)'(NUM_BANKS);

    cmd_t                 cmd;
    logic                 ba_ok;
    logic                 allow;
    bank_state_t          bank_st [NUM_BANKS];
    logic [NUM_BANKS-1:0] busy;
    logic [NUM_BANKS-1:0] hit;

    assign cmd   = decode_cmd(sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n);
    assign ba_ok = ({1'b0, sdr_ba} < NumBnk);

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic [2:0] st;
        assign hit[g] = (sdr_ba == BA_W'(g));
        sdr_bank_fsm #(
            .TmrW (TmrW),
            .TRcd (T_RCD),
            .TRp  (T_RP),
            .TRfc (T_RFC)
        ) u_fsm (
            .clk_i   (sdram_clk),
            .rst_i   (sdram_reset),
            .en_i    (sdr_init_done),
            .cmd_i   (cmd),
            .hit_i   (hit[g]),
            .a10_i   (sdr_a10),
            .allow_i (allow),
            .state_o (st),
            .busy_o  (busy[g])
        );
        assign bank_st[g]   = bank_state_t'(st);
        assign bank_open[g] = (bank_st[g] == BkActivating) || (bank_st[g] == BkActive);
    end

    bank_state_t     sel_st;
    logic            sel_busy, all_idle, any_act;
    logic [BA_W-1:0] first_ni, first_act, bank_d;
    viol_code_t      code_d;

    // Scanning downward leaves the lowest offending index in first_ni / first_act.
    always_comb begin
        sel_st    = BkIdle;
        sel_busy  = 1'b0;
        all_idle  = 1'b1;
        any_act   = 1'b0;
        first_ni  = '0;
        first_act = '0;
        for (int i = int'(NUM_BANKS) - 1; i >= 0; i--) begin
            if (bank_st[i] != BkIdle || busy[i]) begin
                all_idle = 1'b0;
                first_ni = BA_W'(i);
            end
            if (bank_st[i] == BkActivating) begin
                any_act   = 1'b1;
                first_act = BA_W'(i);
            end
            if (hit[i]) begin
                sel_st   = bank_st[i];
                sel_busy = busy[i];
            end
        end

        code_d = VNone;
        bank_d = sdr_ba;
        case (cmd)
            CmdAct: begin
                if (!ba_ok)                                               code_d = VBadBank;
                else if (sel_st == BkActivating || sel_st == BkActive)    code_d = VActNotIdle;
                else if (sel_st != BkIdle || sel_busy)                    code_d = VTiming;
            end
            CmdRd, CmdWr: begin
                if (!ba_ok)                      code_d = VBadBank;
                else if (sel_st == BkActivating) code_d = VTiming;
                else if (sel_st != BkActive)     code_d = VRwNotActive;
            end
            CmdPre: begin
                if (sdr_a10) begin
                    if (any_act) begin
                        code_d = VTiming;
                        bank_d = first_act;
                    end
                end else if (!ba_ok) begin
                    code_d = VBadBank;
                end else if (sel_st == BkActivating) begin
                    code_d = VTiming;
                end
            end
            CmdRef, CmdLmr: begin
                if (!all_idle) begin
                    code_d = VNotAllIdle;
                    bank_d = first_ni;
                end
            end
            default: ;
        endcase
        if (!sdr_init_done) begin
            code_d = VNone;
        end
    end

    assign allow = (code_d == VNone);

    logic             viol_q;
    logic [2:0]       code_q;
    logic [BA_W-1:0]  bank_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (code_d != VNone && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_reset) begin
            viol_q <= 1'b0;
            code_q <= 3'd0;
            bank_q <= '0;
            cnt_q  <= '0;
        end else begin
            viol_q <= (code_d != VNone);
            code_q <= code_d;
            bank_q <= (code_d != VNone) ? bank_d : '0;
            cnt_q  <= cnt_d;
        end
    end

    assign viol      = viol_q;
    assign viol_code = code_q;
    assign viol_bank = bank_q;
    assign viol_cnt  = cnt_q;

endmodule

// File: tb/tb_sdr_bank_monitor.sv
// Directed bench for sdr_bank_monitor: a vector table for the main protocol walk,
// then hand sequences for bad-bank, counter saturation and mid-run reset.
module tb_sdr_bank_monitor;

    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] LMR = 4'b0000;
    localparam logic [3:0] BST = 4'b0110;
    localparam logic [3:0] NOP = 4'b0111;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       init = 1'b0;
    logic [3:0] cmd  = NOP;
    logic [1:0] ba   = 2'd0;
    logic       a10  = 1'b0;

    logic        viol_a, viol_b;
    logic [2:0]  code_a, code_b;
    logic [1:0]  bank_a, bank_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [3:0]  open_a;
    logic [1:0]  open_b;

    always #5 clk = ~clk;

    sdr_bank_monitor dut (
        .sdram_clk     (clk),
        .sdram_reset   (rst),
        .sdr_init_done (init),
        .sdr_cs_n      (cmd[3]),
        .sdr_ras_n     (cmd[2]),
        .sdr_cas_n     (cmd[1]),
        .sdr_we_n      (cmd[0]),
        .sdr_ba        (ba),
        .sdr_a10       (a10),
        .viol          (viol_a),
        .viol_code     (code_a),
        .viol_bank     (bank_a),
        .viol_cnt      (cnt_a),
        .bank_open     (open_a)
    );

    sdr_bank_monitor #(
        .NUM_BANKS (2),
        .CNT_W     (4)
    ) dut2 (
        .sdram_clk     (clk),
        .sdram_reset   (rst),
        .sdr_init_done (init),
        .sdr_cs_n      (cmd[3]),
        .sdr_ras_n     (cmd[2]),
        .sdr_cas_n     (cmd[1]),
        .sdr_we_n      (cmd[0]),
        .sdr_ba        (ba),
        .sdr_a10       (a10),
        .viol          (viol_b),
        .viol_code     (code_b),
        .viol_bank     (bank_b),
        .viol_cnt      (cnt_b),
        .bank_open     (open_b)
    );

    typedef struct {
        logic [3:0] cmd;
        logic [1:0] ba;
        logic       a10;
        logic       init;
        logic       ev;
        logic [2:0] ecode;
        logic [1:0] ebank;
        logic [3:0] eopen;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] c, input logic [1:0] b, input logic a, input logic in,
                       input logic ev, input logic [2:0] ec, input logic [1:0] eb,
                       input logic [3:0] eo);
        vec_t v;
        v.cmd = c; v.ba = b; v.a10 = a; v.init = in;
        v.ev = ev; v.ecode = ec; v.ebank = eb; v.eopen = eo;
        vq.push_back(v);
    endtask

    // Drive one command at a negedge; it is sampled on the next posedge and
    // its registered result is visible when this returns (next negedge).
    task automatic cyc(input logic [3:0] c, input logic [1:0] b, input logic a);
        cmd = c;
        ba  = b;
        a10 = a;
        @(negedge clk);
    endtask

    int ecnt;

    initial begin
        //  cmd  ba a10 init ev code bank open
        add(RD,  0, 0, 0,  0, 0, 0, 4'b0000);  // 0  init low: ignored
        add(NOP, 0, 0, 1,  0, 0, 0, 4'b0000);
        add(ACT, 1, 0, 1,  0, 0, 0, 4'b0010);  // 2
        add(NOP, 0, 0, 1,  0, 0, 0, 4'b0010);
        add(RD,  1, 0, 1,  0, 0, 0, 4'b0010);  // 4  exactly tRCD
        add(PRE, 1, 0, 1,  0, 0, 0, 4'b0000);
        add(NOP, 0, 0, 1,  0, 0, 0, 4'b0000);
        add(ACT, 1, 0, 1,  0, 0, 0, 4'b0010);
        add(RD,  1, 0, 1,  1, 4, 1, 4'b0010);  // 8  tRCD-1
        add(NOP, 0, 0, 1,  0, 0, 0, 4'b0010);
        add(PRE, 1, 0, 1,  0, 0, 0, 4'b0000);
        add(NOP, 0, 0, 1,  0, 0, 0, 4'b0000);
        add(ACT, 0, 0, 1,  0, 0, 0, 4'b0001);  // 12
        add(ACT, 2, 0, 1,  0, 0, 0, 4'b0101);
        add(NOP, 0, 0, 1,  0, 0, 0, 4'b0101);
        add(PRE, 3, 1, 1,  0, 0, 0, 4'b0000);  // 15 precharge all
        add(ACT, 0, 0, 1,  1, 4, 0, 4'b0000);
        add(ACT, 0, 0, 1,  0, 0, 0, 4'b0001);
        add(PRE, 2, 1, 1,  1, 4, 0, 4'b0001);  // 18 PRE-all hits ACTIVATING b0
        add(NOP, 0, 0, 1,  0, 0, 0, 4'b0001);
        add(PRE, 0, 0, 1,  0, 0, 0, 4'b0000);
        add(NOP, 0, 0, 1,  0, 0, 0, 4'b0000);
        add(ACT, 3, 0, 1,  0, 0, 0, 4'b1000);  // 22
        add(NOP, 0, 0, 1,  0, 0, 0, 4'b1000);
        add(REF, 0, 0, 1,  1, 5, 3, 4'b1000);
        add(ACT, 3, 0, 1,  1, 1, 3, 4'b1000);
        add(PRE, 3, 0, 1,  0, 0, 0, 4'b0000);  // 26
        add(REF, 0, 0, 1,  1, 5, 3, 4'b0000);  // tRP-1
        add(REF, 0, 0, 1,  0, 0, 0, 4'b0000);  // 28 legal refresh
        add(ACT, 0, 0, 1,  1, 4, 0, 4'b0000);
        add(LMR, 2, 0, 1,  1, 5, 0, 4'b0000);
        add(RD,  1, 0, 1,  1, 2, 1, 4'b0000);
        add(NOP, 0, 0, 1,  0, 0, 0, 4'b0000);
        add(NOP, 0, 0, 1,  0, 0, 0, 4'b0000);
        add(ACT, 2, 0, 1,  1, 4, 2, 4'b0000);  // 34 tRFC-1
        add(ACT, 2, 0, 1,  0, 0, 0, 4'b0100);  // 35 exactly tRFC
        add(NOP, 0, 0, 1,  0, 0, 0, 4'b0100);
        add(WR,  2, 1, 1,  0, 0, 0, 4'b0000);  // 37 auto-precharge
        add(RD,  2, 0, 1,  1, 2, 2, 4'b0000);
        add(NOP, 0, 0, 1,  0, 0, 0, 4'b0000);
        add(LMR, 0, 0, 1,  0, 0, 0, 4'b0000);  // 40
        add(BST, 0, 0, 1,  0, 0, 0, 4'b0000);
        add(ACT, 0, 0, 1,  0, 0, 0, 4'b0001);
        add(NOP, 0, 0, 0,  0, 0, 0, 4'b0000);  // 43 init drop forces IDLE
        add(REF, 0, 0, 0,  0, 0, 0, 4'b0000);
        add(RD,  0, 0, 0,  0, 0, 0, 4'b0000);
        add(NOP, 0, 0, 1,  0, 0, 0, 4'b0000);
        add(PRE, 1, 0, 1,  0, 0, 0, 4'b0000);  // 47 PRE to IDLE bank

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset viol", viol_a, 0);
        chk("reset code", code_a, 0);
        chk("reset bank", bank_a, 0);
        chk("reset cnt", cnt_a, 0);
        chk("reset open", open_a, 0);

        ecnt = 0;
        foreach (vq[i]) begin
            init = vq[i].init;
            cyc(vq[i].cmd, vq[i].ba, vq[i].a10);
            if (vq[i].ev) ecnt++;
            chk($sformatf("v%0d viol", i), viol_a, vq[i].ev);
            chk($sformatf("v%0d open", i), open_a, vq[i].eopen);
            chk($sformatf("v%0d cnt", i), cnt_a, ecnt);
            if (vq[i].ev) begin
                chk($sformatf("v%0d code", i), code_a, vq[i].ecode);
                chk($sformatf("v%0d bank", i), bank_a, vq[i].ebank);
            end
        end

        // Command during reset is ignored; all state clears.
        rst = 1'b1;
        cyc(RD, 0, 0);
        rst = 1'b0;
        chk("rst1 viol", viol_a, 0);
        chk("rst1 cnt", cnt_a, 0);
        chk("rst1 open", open_a, 0);
        chk("rst1 cnt2", cnt_b, 0);

        cyc(ACT, 3, 0);
        chk("badbank viol", viol_b, 1);
        chk("badbank code", code_b, 6);
        chk("badbank bank", bank_b, 3);
        chk("badbank cnt", cnt_b, 1);
        chk("badbank open", open_b, 0);

        for (int k = 0; k < 21; k++) begin
            cyc(RD, 0, 0);
            chk($sformatf("sat%0d viol", k), viol_b, 1);
            chk($sformatf("sat%0d code", k), code_b, 2);
            chk($sformatf("sat%0d cnt", k), cnt_b, (k + 2 > 15) ? 15 : k + 2);
        end

        cyc(ACT, 1, 0);
        chk("pre-rst viol", viol_b, 0);
        chk("pre-rst cnt", cnt_b, 15);
        chk("pre-rst open", open_b, 2'b10);

        rst = 1'b1;
        cyc(RD, 1, 0);
        rst = 1'b0;
        chk("rst2 viol", viol_b, 0);
        chk("rst2 code", code_b, 0);
        chk("rst2 bank", bank_b, 0);
        chk("rst2 cnt", cnt_b, 0);
        chk("rst2 open", open_b, 0);
        chk("rst2 open a", open_a, 0);
        chk("rst2 cnt a", cnt_a, 0);
        cyc(NOP, 0, 0);
        chk("post-rst open", open_b, 0);
        chk("post-rst viol", viol_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
